// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetches instructions from a registered-read instruction memory and hands
//   them to the decoder through a valid/ready handshake backed by a 2-entry
//   buffer. Supports start, redirect (jump/branch) and halt.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, start_pc   begin fetching at start_pc (ignored while busy)
//   redirect_valid,   flush and resume at redirect_pc (ignored while idle)
//   redirect_pc
//   halt_req          stop fetching and flush (ignored while idle)
//   busy              high while running
//   done              one-cycle pulse after a halt
//   im_rd_addr        memory read address (the PC register)
//   im_rd_data        memory read data, one cycle after im_rd_addr is captured
//   inst_valid, inst_data, inst_pc, inst_ready
//                     decoder handshake; inst_data/inst_pc show the buffer head
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned INST_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] im_rd_addr,
    input  logic [INST_WIDTH-1:0] im_rd_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pc, resp_pc;
    logic                    resp_pending;
    logic [1:0]              count;
    logic [INST_WIDTH-1:0]   data0, data1;
    logic [ADDR_WIDTH-1:0]   addr0, addr1;
    logic                    done_q;

    logic                    do_start, do_redirect, do_flush;
    logic                    issue, push, pop;
    logic [2:0]              occupancy;

    // Control decode: halt wins over redirect; flush cycles neither push nor pop.
    always_comb begin
        state_next  = state;
        do_start    = 1'b0;
        do_redirect = 1'b0;
        do_flush    = 1'b0;
        issue       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        occupancy   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    do_flush   = 1'b1;
                    state_next = IDLE;
                end else if (redirect_valid) begin
                    do_flush    = 1'b1;
                    do_redirect = 1'b1;
                end else begin
                    pop  = inst_valid && inst_ready;
                    push = resp_pending;
                    // Credit check: entries held plus the response in flight,
                    // less what leaves this cycle, must leave room for one more.
                    occupancy = {1'b0, count} + {2'b00, resp_pending} - {2'b00, pop};
                    issue     = (occupancy < 3'd2);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= '0;
            resp_pc      <= '0;
            resp_pending <= 1'b0;
            count        <= '0;
            data0        <= '0;
            data1        <= '0;
            addr0        <= '0;
            addr1        <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state == RUN) && halt_req;
            if (do_start) begin
                pc           <= start_pc & ALIGN_MASK;
                count        <= '0;
                resp_pending <= 1'b0;
            end else if (do_flush) begin
                if (do_redirect) begin
                    pc <= redirect_pc & ALIGN_MASK;
                end
                count        <= '0;
                resp_pending <= 1'b0;
            end else if (state == RUN) begin
                resp_pending <= issue;
                if (issue) begin
                    pc      <= pc + PC_STEP;
                    resp_pc <= pc;
                end
                // Shift-register FIFO: entry 0 is always the head.
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            data0 <= im_rd_data;
                            addr0 <= resp_pc;
                        end else begin
                            data1 <= im_rd_data;
                            addr1 <= resp_pc;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        data0 <= data1;
                        addr0 <= addr1;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            data0 <= im_rd_data;
                            addr0 <= resp_pc;
                        end else begin
                            data0 <= data1;
                            addr0 <= addr1;
                            data1 <= im_rd_data;
                            addr1 <= resp_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy       = (state == RUN);
    assign done       = done_q;
    assign im_rd_addr = pc;
    assign inst_valid = (count != 2'd0);
    assign inst_data  = data0;
    assign inst_pc    = addr0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed stimulus with a scoreboard of
// expected instruction addresses and a monitor that checks every accepted
// instruction against it.
module tb_instruction_fetch_unit;

    localparam int AW = 16;
    localparam int IW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt_req = 1'b0;
    logic          inst_ready = 1'b0;
    logic [IW-1:0] im_rd_data = '0;
    logic          busy, done, inst_valid;
    logic [AW-1:0] im_rd_addr, inst_pc;
    logic [IW-1:0] inst_data;

    int unsigned   n_checks = 0;
    int unsigned   n_pass = 0;
    logic [AW-1:0] exp_q[$];

    instruction_fetch_unit #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_pc      (start_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .busy          (busy),
        .done          (done),
        .im_rd_addr    (im_rd_addr),
        .im_rd_data    (im_rd_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
        return {8{a, ~a}};
    endfunction

    // Memory with one-cycle registered read.
    always @(posedge clk) im_rd_data <= inst_of(im_rd_addr);

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] first, input int n);
        logic [AW-1:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + AW'(4);
        end
    endtask

    // Monitor: a transfer seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_inst: got inst_pc %0h, expected no transfer", inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst_data", inst_data, inst_of(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        // Reset values
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", im_rd_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_data", inst_data, 0);
        check("rst_pc", inst_pc, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Halt/redirect ignored while idle
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        halt_req = 1'b0; redirect_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rd_addr", im_rd_addr, 0);
        tick();

        // Stream from 0x0010 with the decoder always ready
        inst_ready = 1'b1;
        start_pc = 16'h0010; start = 1'b1;
        push_exp(16'h0010, 10);
        tick();                                   // edge k
        start = 1'b1; start_pc = 16'h0400;        // start while busy: ignored
        check("start_busy", busy, 1);
        check("start_rd_addr", im_rd_addr, 16'h0010);
        check("start_valid_k", inst_valid, 0);
        tick();                                   // edge k+1
        start = 1'b0;
        check("start_valid_k1", inst_valid, 0);
        check("start_rd_addr_k1", im_rd_addr, 16'h0014);
        tick();                                   // edge k+2
        for (int i = 0; i < 6; i++) begin
            check("stream_valid", inst_valid, 1);
            check("stream_rd_addr", im_rd_addr, 16'h0018 + AW'(4 * i));
            tick();
        end

        // Backpressure for 5 cycles
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", inst_valid, 1);
            check("bp_head_pc", inst_pc, 16'h0028);
            check("bp_head_data", inst_data, inst_of(16'h0028));
            check("bp_rd_addr_frozen", im_rd_addr, 16'h0030);
            tick();
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("release_valid", inst_valid, 1);
            tick();
        end
        inst_ready = 1'b0;
        check("stream_drained", exp_q.size(), 0);

        // Fill the buffer, then redirect to 0x0103
        tick();
        check("full_head_pc", inst_pc, 16'h0038);
        tick();
        check("full_hold_pc", inst_pc, 16'h0038);
        redirect_pc = 16'h0103; redirect_valid = 1'b1;
        tick();                                   // edge k
        redirect_valid = 1'b0;
        check("redir_flush_valid", inst_valid, 0);
        check("redir_rd_addr", im_rd_addr, 16'h0100);
        check("redir_busy", busy, 1);
        tick();
        check("redir_valid_k1", inst_valid, 0);
        check("redir_rd_addr_k1", im_rd_addr, 16'h0104);
        tick();
        check("redir_valid_k2", inst_valid, 1);
        push_exp(16'h0100, 4);
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("redir_drained", exp_q.size(), 0);

        // Halt together with redirect
        inst_ready = 1'b0;
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0300;
        tick();
        halt_req = 1'b0; redirect_valid = 1'b0;
        check("halt_busy", busy, 0);
        check("halt_valid", inst_valid, 0);
        check("halt_done", done, 1);
        tick();
        check("halt_done_pulse", done, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("halt_idle_valid", inst_valid, 0);
            check("halt_idle_busy", busy, 0);
            tick();
        end

        // Wrap-around from 0xFFF8 (low bits of start_pc ignored)
        start_pc = 16'hFFFB; start = 1'b1;
        push_exp(16'hFFF8, 4);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("wrap_first_valid", inst_valid, 1);
        for (int i = 0; i < 4; i++) tick();
        inst_ready = 1'b0;
        check("wrap_drained", exp_q.size(), 0);
        tick();
        check("wrap_full_pc", inst_pc, 16'h0008);
        check("wrap_full_valid", inst_valid, 1);
        check("wrap_rd_addr", im_rd_addr, 16'h0010);

        // Asynchronous reset with a full buffer
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rd_addr", im_rd_addr, 0);
        check("arst_valid", inst_valid, 0);
        check("arst_data", inst_data, 0);
        check("arst_pc", inst_pc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_no_fetch", inst_valid, 0);
        check("arst_idle", busy, 0);
        start_pc = 16'h0200; start = 1'b1;
        push_exp(16'h0200, 3);
        inst_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("restart_valid", inst_valid, 1);
        for (int i = 0; i < 3; i++) tick();
        inst_ready = 1'b0;
        check("restart_drained", exp_q.size(), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
